// File: rtl/hamming_pkg.sv
// Shared types, bit positions and helpers for the SECDED (8,4) Hamming controller.
package hamming_pkg;

   typedef enum logic [1:0] {
      INACTIVO   = 2'd0,
      DECODIFICA = 2'd1,
      ENTREGA    = 2'd2
   } estado_t;

   // Codeword layout: bit0 overall parity, bits 1/2/4 Hamming parity, bits 3/5/6/7 data
   localparam int POS_PT = 0;
   localparam int POS_P1 = 1;
   localparam int POS_P2 = 2;
   localparam int POS_P4 = 4;
   localparam int POS_D0 = 3;
   localparam int POS_D1 = 5;
   localparam int POS_D2 = 6;
   localparam int POS_D3 = 7;

   function automatic logic [3:0] extrae_dato(input logic [7:0] palabra);
      return {palabra[POS_D3], palabra[POS_D2], palabra[POS_D1], palabra[POS_D0]};
   endfunction

endpackage

// File: rtl/hamming_if.sv
// Handshake and result bus between the channel stage, the controller and the consumer.
interface hamming_if #(
   parameter int ANCHO_CNT = 8
);
   logic                 ent_valido;
   logic                 ent_listo;
   logic [7:0]           palabra_ent;
   logic                 iny_hab;
   logic [7:0]           iny_mascara;
   logic                 sal_valido;
   logic                 sal_listo;
   logic [7:0]           palabra_corr;
   logic [3:0]           dato_sal;
   logic [2:0]           sindrome;
   logic                 error_simple;
   logic                 error_doble;
   logic [ANCHO_CNT-1:0] cnt_simple;
   logic [ANCHO_CNT-1:0] cnt_doble;
   logic                 limpiar_cnt;

   // master: producer/consumer side; slave: the controller
   modport master (
      output ent_valido, palabra_ent, iny_hab, iny_mascara, sal_listo, limpiar_cnt,
      input  ent_listo, sal_valido, palabra_corr, dato_sal, sindrome,
             error_simple, error_doble, cnt_simple, cnt_doble
   );

   modport slave (
      input  ent_valido, palabra_ent, iny_hab, iny_mascara, sal_listo, limpiar_cnt,
      output ent_listo, sal_valido, palabra_corr, dato_sal, sindrome,
             error_simple, error_doble, cnt_simple, cnt_doble
   );

endinterface

// File: rtl/controlador_hamming_sindrome.sv
// Combinational SECDED (8,4) syndrome and error classification.
module sindrome_secded
   import hamming_pkg::*;
(
   input  logic [7:0] palabra_i,
   output logic [2:0] sindrome_o,
   output logic       paridad_o,
   output logic       error_simple_o,
   output logic       error_doble_o
);

   logic s1, s2, s3;

   assign s1 = palabra_i[POS_P1] ^ palabra_i[POS_D0] ^ palabra_i[POS_D1] ^ palabra_i[POS_D3];
   assign s2 = palabra_i[POS_P2] ^ palabra_i[POS_D0] ^ palabra_i[POS_D2] ^ palabra_i[POS_D3];
   assign s3 = palabra_i[POS_P4] ^ palabra_i[POS_D1] ^ palabra_i[POS_D2] ^ palabra_i[POS_D3];

   assign sindrome_o = {s3, s2, s1};
   assign paridad_o  = ^palabra_i;

   // Odd overall parity means exactly one flipped bit (syndrome 0 points at the parity bit)
   assign error_simple_o = paridad_o;
   assign error_doble_o  = !paridad_o && (sindrome_o != 3'd0);

endmodule

// File: rtl/controlador_hamming.sv
// Capture / decode / deliver sequencer around the SECDED (8,4) decoder with
// optional error injection and saturating error counters.
//
//  state      | meaning
//  INACTIVO   | waiting for a word, ent_listo=1
//  DECODIFICA | one cycle: syndrome, flags and corrected word registered
//  ENTREGA    | result held on the output port until sal_listo
module controlador_hamming
   import hamming_pkg::*;
#(
   parameter int ANCHO_CNT = 8
) (
   input  logic     reloj,
   input  logic     rst_n,
   hamming_if.slave bus
);

   localparam logic [ANCHO_CNT-1:0] CNT_MAX = '1;

   estado_t              estado_q, estado_d;
   logic [7:0]           r_q, r_d;
   logic [7:0]           corr_q, corr_d;
   logic [3:0]           dato_q, dato_d;
   logic [2:0]           sind_q, sind_d;
   logic                 es_q, es_d;
   logic                 ed_q, ed_d;
   logic [ANCHO_CNT-1:0] cnt_simple_q, cnt_simple_d;
   logic [ANCHO_CNT-1:0] cnt_doble_q, cnt_doble_d;

   logic [2:0] sind_w;
   logic       paridad_w;
   logic       es_w;
   logic       ed_w;
   logic [7:0] corr_w;
   logic       entrega_ok;

   sindrome_secded u_sindrome (
      .palabra_i      (r_q),
      .sindrome_o     (sind_w),
      .paridad_o      (paridad_w),
      .error_simple_o (es_w),
      .error_doble_o  (ed_w)
   );

   assign corr_w     = paridad_w ? (r_q ^ (8'd1 << sind_w)) : r_q;
   assign entrega_ok = (estado_q == ENTREGA) && bus.sal_listo;

   always_comb begin
      estado_d = estado_q;
      r_d      = r_q;
      corr_d   = corr_q;
      dato_d   = dato_q;
      sind_d   = sind_q;
      es_d     = es_q;
      ed_d     = ed_q;
      case (estado_q)
         INACTIVO: begin
            if (bus.ent_valido) begin
               r_d      = bus.palabra_ent ^ (bus.iny_hab ? bus.iny_mascara : 8'h00);
               estado_d = DECODIFICA;
            end
         end
         DECODIFICA: begin
            corr_d   = corr_w;
            dato_d   = extrae_dato(corr_w);
            sind_d   = sind_w;
            es_d     = es_w;
            ed_d     = ed_w;
            estado_d = ENTREGA;
         end
         ENTREGA: begin
            if (bus.sal_listo) estado_d = INACTIVO;
         end
         default: estado_d = INACTIVO;
      endcase
   end

   // Clear wins over a same-cycle increment; counts stick at the maximum
   always_comb begin
      cnt_simple_d = cnt_simple_q;
      cnt_doble_d  = cnt_doble_q;
      if (bus.limpiar_cnt) begin
         cnt_simple_d = '0;
         cnt_doble_d  = '0;
      end else if (entrega_ok) begin
         if (es_q && (cnt_simple_q != CNT_MAX)) cnt_simple_d = cnt_simple_q + 1'b1;
         if (ed_q && (cnt_doble_q != CNT_MAX))  cnt_doble_d  = cnt_doble_q + 1'b1;
      end
   end

   always_ff @(posedge reloj) begin
      if (!rst_n) begin
         estado_q     <= INACTIVO;
         r_q          <= '0;
         corr_q       <= '0;
         dato_q       <= '0;
         sind_q       <= '0;
         es_q         <= 1'b0;
         ed_q         <= 1'b0;
         cnt_simple_q <= '0;
         cnt_doble_q  <= '0;
      end else begin
         estado_q     <= estado_d;
         r_q          <= r_d;
         corr_q       <= corr_d;
         dato_q       <= dato_d;
         sind_q       <= sind_d;
         es_q         <= es_d;
         ed_q         <= ed_d;
         cnt_simple_q <= cnt_simple_d;
         cnt_doble_q  <= cnt_doble_d;
      end
   end

   assign bus.ent_listo    = (estado_q == INACTIVO);
   assign bus.sal_valido   = (estado_q == ENTREGA);
   assign bus.palabra_corr = corr_q;
   assign bus.dato_sal     = dato_q;
   assign bus.sindrome     = sind_q;
   assign bus.error_simple = es_q;
   assign bus.error_doble  = ed_q;
   assign bus.cnt_simple   = cnt_simple_q;
   assign bus.cnt_doble    = cnt_doble_q;

endmodule

// File: tb/tb_controlador_hamming.sv
// Directed bench for controlador_hamming with 2-bit counters.
module tb_controlador_hamming;

   logic reloj;
   logic rst_n;
   int   vectors;
   int   miscompares;

   hamming_if #(.ANCHO_CNT(2)) bus ();

   controlador_hamming #(.ANCHO_CNT(2)) dut (
      .reloj (reloj),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      reloj = 1'b0;
      forever #5 reloj = ~reloj;
   end

   task automatic tick();
      @(posedge reloj);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept a word in INACTIVO and walk to ENTREGA, checking handshake timing
   task automatic send(input logic [7:0] w, input logic hab, input logic [7:0] m);
      chk("listo_antes", 32'(bus.ent_listo), 32'd1);
      bus.ent_valido  = 1'b1;
      bus.palabra_ent = w;
      bus.iny_hab     = hab;
      bus.iny_mascara = m;
      tick();
      bus.ent_valido  = 1'b0;
      bus.iny_hab     = 1'b0;
      bus.iny_mascara = 8'h00;
      chk("dec_listo", 32'(bus.ent_listo), 32'd0);
      chk("dec_valido", 32'(bus.sal_valido), 32'd0);
      tick();
      chk("ent_valido", 32'(bus.sal_valido), 32'd1);
      chk("ent_listo", 32'(bus.ent_listo), 32'd0);
   endtask

   task automatic expect_res(input string tag, input logic [7:0] corr, input logic [3:0] dato,
                             input logic [2:0] sind, input logic es, input logic ed);
      chk({tag, "_corr"}, 32'(bus.palabra_corr), 32'(corr));
      chk({tag, "_dato"}, 32'(bus.dato_sal), 32'(dato));
      chk({tag, "_sind"}, 32'(bus.sindrome), 32'(sind));
      chk({tag, "_es"}, 32'(bus.error_simple), 32'(es));
      chk({tag, "_ed"}, 32'(bus.error_doble), 32'(ed));
   endtask

   task automatic deliver(input logic limp);
      bus.sal_listo   = 1'b1;
      bus.limpiar_cnt = limp;
      tick();
      bus.sal_listo   = 1'b0;
      bus.limpiar_cnt = 1'b0;
      chk("post_valido", 32'(bus.sal_valido), 32'd0);
      chk("post_listo", 32'(bus.ent_listo), 32'd1);
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst_n           = 1'b0;
      bus.ent_valido  = 1'b0;
      bus.palabra_ent = 8'h00;
      bus.iny_hab     = 1'b0;
      bus.iny_mascara = 8'h00;
      bus.sal_listo   = 1'b0;
      bus.limpiar_cnt = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      chk("rst_listo", 32'(bus.ent_listo), 32'd1);
      chk("rst_valido", 32'(bus.sal_valido), 32'd0);
      expect_res("rst", 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
      chk("rst_cs", 32'(bus.cnt_simple), 32'd0);
      chk("rst_cd", 32'(bus.cnt_doble), 32'd0);

      // Clean word
      send(8'hFF, 1'b0, 8'h00);
      expect_res("limpia", 8'hFF, 4'hF, 3'd0, 1'b0, 1'b0);
      deliver(1'b0);
      chk("limpia_cs", 32'(bus.cnt_simple), 32'd0);
      chk("limpia_cd", 32'(bus.cnt_doble), 32'd0);

      // Injected single error on bit 5
      send(8'hFF, 1'b1, 8'h20);
      expect_res("simple5", 8'hFF, 4'hF, 3'd5, 1'b1, 1'b0);
      chk("simple5_cs_pre", 32'(bus.cnt_simple), 32'd0);
      deliver(1'b0);
      chk("simple5_cs", 32'(bus.cnt_simple), 32'd1);

      // Overall-parity bit error
      send(8'h01, 1'b0, 8'h00);
      expect_res("paridad", 8'h00, 4'h0, 3'd0, 1'b1, 1'b0);
      deliver(1'b0);
      chk("paridad_cs", 32'(bus.cnt_simple), 32'd2);

      // Double error
      send(8'h06, 1'b0, 8'h00);
      expect_res("doble", 8'h06, 4'h0, 3'd3, 1'b0, 1'b1);
      deliver(1'b0);
      chk("doble_cd", 32'(bus.cnt_doble), 32'd1);
      chk("doble_cs", 32'(bus.cnt_simple), 32'd2);

      // Backpressure: second word waits on ent_valido while the first is held
      send(8'h00, 1'b0, 8'h00);
      bus.ent_valido  = 1'b1;
      bus.palabra_ent = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valido", 32'(bus.sal_valido), 32'd1);
         chk("bp_listo", 32'(bus.ent_listo), 32'd0);
         chk("bp_corr", 32'(bus.palabra_corr), 32'h00);
      end
      bus.sal_listo = 1'b1;
      tick();
      bus.sal_listo = 1'b0;
      chk("bp_hs_listo", 32'(bus.ent_listo), 32'd1);
      chk("bp_hs_valido", 32'(bus.sal_valido), 32'd0);
      chk("bp_hs_corr", 32'(bus.palabra_corr), 32'h00);
      tick();
      bus.ent_valido = 1'b0;
      chk("bp_tomada", 32'(bus.ent_listo), 32'd0);
      tick();
      chk("bp2_valido", 32'(bus.sal_valido), 32'd1);
      expect_res("bp2", 8'hFF, 4'hF, 3'd0, 1'b0, 1'b0);
      deliver(1'b0);

      // Saturation of the 2-bit single counter (two singles already counted)
      send(8'hFF, 1'b1, 8'h02);
      expect_res("sat1", 8'hFF, 4'hF, 3'd1, 1'b1, 1'b0);
      deliver(1'b0);
      chk("sat1_cs", 32'(bus.cnt_simple), 32'd3);
      send(8'hFF, 1'b1, 8'h80);
      expect_res("sat2", 8'hFF, 4'hF, 3'd7, 1'b1, 1'b0);
      deliver(1'b0);
      chk("sat2_cs", 32'(bus.cnt_simple), 32'd3);
      send(8'hFF, 1'b1, 8'h01);
      expect_res("sat3", 8'hFF, 4'hF, 3'd0, 1'b1, 1'b0);
      deliver(1'b0);
      chk("sat3_cs", 32'(bus.cnt_simple), 32'd3);

      // Clear together with a double-error handshake
      send(8'h06, 1'b0, 8'h00);
      deliver(1'b1);
      chk("limpiar_cs", 32'(bus.cnt_simple), 32'd0);
      chk("limpiar_cd", 32'(bus.cnt_doble), 32'd0);

      // Reset while decoding aborts the word and clears counters
      send(8'h01, 1'b0, 8'h00);
      deliver(1'b0);
      chk("prerst_cs", 32'(bus.cnt_simple), 32'd1);
      bus.ent_valido  = 1'b1;
      bus.palabra_ent = 8'hDF;
      tick();
      bus.ent_valido = 1'b0;
      chk("abort_dec", 32'(bus.ent_listo), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_listo", 32'(bus.ent_listo), 32'd1);
      chk("abort_valido", 32'(bus.sal_valido), 32'd0);
      chk("abort_cs", 32'(bus.cnt_simple), 32'd0);
      expect_res("abort", 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
      tick();
      chk("abort_valido2", 32'(bus.sal_valido), 32'd0);
      tick();
      chk("abort_valido3", 32'(bus.sal_valido), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
